hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
- Parametrised hazard/forwarding controller for the in-order pipeline datapath.
- Replaces the external ForwardA/ForwardB drive and the tied-high PC_write/IF_ID_Write.
- Keeps its own shadow pipeline of destination tags (valid, rd, reg_write, mem_read) for DEPTH post-ID stages.
- From that pipeline it generates per-source forward selects, load-use stalls and branch flushes for NUM_SRC read ports.

Parameters:
- REG_AW, 5, register address width; register 0 is hardwired zero.
- NUM_SRC, 2, source operands per instruction (Rs, Rt, ...).
- DEPTH, 3, tracked stages after ID: index 0 = EX, 1 = MEM, 2 = WB, ...; DEPTH >= 3.
- LOAD_READY, 2, first stage index where load data is forwardable; 1 <= LOAD_READY < DEPTH.
- BR_STAGE, 1, stage index in which branch_taken is resolved; 0 <= BR_STAGE < DEPTH.
- SEL_W, $clog2(DEPTH), derived width of one forward select field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*REG_AW  ID source register numbers, port i at [i*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  per-source "operand actually read" flag.
- id_rd  in  REG_AW  ID destination, after RegDst.
- id_reg_write  in  1  ID RegWrite.
- id_mem_read  in  1  ID MemRead (load).
- branch_taken  in  1  taken branch in stage BR_STAGE.
- fwd_sel  out  NUM_SRC*SEL_W  EX operand mux select per source; 0 = register file, k = result held in stage k.
- pc_write  out  1  PC enable.
- if_id_write  out  1  IF/ID enable.
- flush  out  BR_STAGE+2  bit 0 = IF/ID, bit 1 = ID/EX, bit j+1 = pipe register feeding stage j.
- stall  out  1  load-use stall this cycle.

Behaviour:
- Shadow pipe registers per stage k: v[k], rd[k], rw[k], mr[k]. EX stage also stores src[i] and used[i].
- Async reset: all v = 0, all src/used = 0. After reset: fwd_sel = 0, stall = 0, pc_write = 1, if_id_write = 1, flush = 0.
- Normal advance, every edge:
  - stage k+1 <= stage k.
  - stage 0 <= ID fields, with v = id_valid.
  - the last stage drops out.
- Producer at stage k is valid for a source s when v[k] & rw[k] & rd[k] == s & s != 0. All outputs are combinational from the current state.
- Forwarding, per EX source i with used[i]:
  - candidate k in 1..DEPTH-1.
  - load producers (mr[k]) qualify only if k >= LOAD_READY.
  - the lowest qualifying k wins (youngest); no candidate -> 0.
  - the register file is write-before-read, so there is no forwarding past the last stage.
- Load-use stall:
  - stall = id_valid & any used ID source matches a load producer at stage k with k+1 < LOAD_READY, k >= 0.
  - With defaults this is a load in EX only, giving 1 bubble.
  - If LOAD_READY = 3, a load in EX or MEM stalls, giving 2 bubbles.
  - On stall: pc_write = 0, if_id_write = 0, flush[1] = 1. Stage 0 receives a bubble (v = 0); older stages advance.
- Branch, when branch_taken = 1:
  - flush[BR_STAGE+1:0] all 1.
  - stall forced 0, pc_write = 1, if_id_write = 1.
  - At the edge, shifted stages 1..BR_STAGE and stage 0 get v = 0; the branch itself and older stages advance untouched.
  - Branch has priority over stall in the same cycle.
- A sustained stall holds ID indefinitely; the shadow pipe drains normally.
- rst asserted mid-operation clears all state immediately; it does not wait for an edge.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - adds outputs stall_cnt[31:0] and flush_cnt[31:0], reset to 0.
  - stall_cnt increments on each edge with stall = 1.
  - flush_cnt increments on each edge with branch_taken = 1.
  - both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF = 0;
  - localparams for stage indices EX = 0, MEM = 1, WB = 2;
  - a struct typedef for a tag entry (v, rd, rw, mr).
- One sub-module, fwd_select: a combinational priority matcher for one source against the DEPTH tags, instantiated NUM_SRC times via generate.

Test Plan:
1. Defaults. add r3 (EX) then add r3 <- r3 in ID. Next cycle fwd_sel[0] = 1 (MEM), stall = 0. One cycle later an independent r3 reader sees fwd_sel = 2.
2. lw r5 in EX; ID uses r5 as src1 (used = 1).
   - stall = 1, pc_write = 0, flush = 2'b10; next cycle stall = 0.
   - When the dependent instruction is in EX: fwd_sel[1] = 2.
3. lw r5 in EX; ID uses r5 only with used = 0 -> stall = 0. Also id_rd = 0 producer with id_reg_write = 1 -> never forwards or stalls.
4. r4 written by both MEM and WB producers -> EX reader gets fwd_sel = 1 (youngest wins).
5. branch_taken = 1 simultaneously with a load-use match:
   - flush = 3'b111, stall = 0, pc_write = 1;
   - next cycle v[0] = v[1] = 0.
6. Assert rst mid-stall. Outputs go to reset values before the next edge. With HAZARD_PERF_CNT_EN, after 3 stalls and 2 branches: stall_cnt = 3, flush_cnt = 2, then reset clears both.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Tag entries carry a fixed-width register number; narrower register files zero-extend into it.
package hazard_pkg;

  localparam int unsigned TAG_AW = 8;
  localparam int unsigned FWD_RF = 0;

  localparam int unsigned EX  = 0;
  localparam int unsigned MEM = 1;
  localparam int unsigned WB  = 2;

  typedef struct packed {
    logic              v;
    logic [TAG_AW-1:0] rd;
    logic              rw;
    logic              mr;
  } tag_t;

  // A stage produces register s when it holds a valid writer of s; r0 never counts.
  function automatic logic producer_match(tag_t t, logic [TAG_AW-1:0] s);
    return t.v && t.rw && (t.rd == s) && (s != '0);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority matcher for one EX source against the post-EX shadow tags.
// The youngest qualifying producer wins; loads qualify only once their data is available.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned SEL_W      = 2
) (
  input  tag_t [DEPTH-1:1] tags,
  input  logic [TAG_AW-1:0] src,
  input  logic              used,
  output logic [SEL_W-1:0]  sel_c
);

  logic found;

  always_comb begin
    sel_c = SEL_W'(FWD_RF);
    found = 1'b0;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (!found && used && producer_match(tags[k], src) &&
          (!tags[k].mr || k >= LOAD_READY)) begin
        sel_c = SEL_W'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller: shadow tag pipeline, forward selects, load-use stall, branch flush.
// Define HAZARD_PERF_CNT_EN to add saturating stall_cnt/flush_cnt event counters.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned BR_STAGE   = 1,
  localparam int unsigned SEL_W     = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      branch_taken,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      pc_write,
  output logic                      if_id_write,
  output logic [BR_STAGE+1:0]       flush,
  output logic                      stall
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               flush_cnt
`endif
);

  if (DEPTH <= WB || LOAD_READY < MEM || LOAD_READY >= DEPTH ||
      BR_STAGE >= DEPTH || REG_AW > TAG_AW) begin : g_bad_cfg
    $error("hazard_forward_unit: unsupported parameter set");
  end

  tag_t [DEPTH-1:0]          tags;
  tag_t [DEPTH-1:0]          tags_nxt;
  tag_t                      id_tag;
  logic [NUM_SRC*REG_AW-1:0] ex_src;
  logic [NUM_SRC-1:0]        ex_used;
  logic                      load_use_c;
  logic                      id_enter_c;

  // A used ID source waiting on a load whose data will not be forwardable in time.
  always_comb begin
    load_use_c = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if ((k + 1 < LOAD_READY) && id_src_used[i] && tags[k].mr &&
            producer_match(tags[k], TAG_AW'(id_src[i*REG_AW +: REG_AW])))
          load_use_c = 1'b1;
      end
    end
  end

  // Branch outranks stall: the stalled instruction is on the wrong path anyway.
  always_comb begin
    stall       = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    flush       = '0;
    if (branch_taken) begin
      flush = '1;
    end else if (id_valid && load_use_c) begin
      stall         = 1'b1;
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      flush[EX + 1] = 1'b1;
    end
  end

  assign id_enter_c = id_valid && !stall && !branch_taken;

  always_comb begin
    id_tag    = '{v: id_valid, rd: TAG_AW'(id_rd), rw: id_reg_write, mr: id_mem_read};
    tags_nxt  = '0;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      tags_nxt[k] = tags[k-1];
      if (branch_taken && k <= BR_STAGE)
        tags_nxt[k].v = 1'b0;
    end
    if (id_enter_c)
      tags_nxt[EX] = id_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags    <= '0;
      ex_src  <= '0;
      ex_used <= '0;
    end else begin
      tags    <= tags_nxt;
      ex_src  <= id_src;
      ex_used <= id_enter_c ? id_src_used : '0;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_select #(
      .DEPTH      (DEPTH),
      .LOAD_READY (LOAD_READY),
      .SEL_W      (SEL_W)
    ) u_fwd_select (
      .tags  (tags[DEPTH-1:1]),
      .src   (TAG_AW'(ex_src[i*REG_AW +: REG_AW])),
      .used  (ex_used[i]),
      .sel_c (fwd_sel[i*SEL_W +: SEL_W])
    );
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (branch_taken && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
